cache_control: RTL
==================

Name: cache_control

Overview:
- Per-request control FSM for the set-associative cache; sits directly upstream of the dirty-bit array.
- Sequences hit/miss handling, dirty-victim writeback and line refill.
- Drives the dirty array's operation/set/way inputs and consumes its dirty_out.
- Also drives the physical-memory handshake and the load strobes for the data/tag/valid/LRU arrays.

Parameters:
s_index, 4, set index width (2**s_index sets)
w_index, 2, way index width (2**w_index ways)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
mem_read  input  1  CPU read request, level, held until mem_resp
mem_write  input  1  CPU write request, level, held until mem_resp
set_idx  input  s_index  set of current request, stable while request held
hit  input  1  tag compare hit (combinational, valid in COMPARE)
hit_way  input  w_index  hitting way when hit=1
lru_way  input  w_index  LRU victim way for set_idx
dirty_in  input  1  dirty bit of (dirty_set, dirty_way), combinational read
pmem_resp  input  1  physical memory completion pulse
mem_resp  output  1  one-cycle CPU completion pulse
dirty_op  output  2  00 idle, 01 mark, 10 unmark
dirty_set  output  s_index  set driven to dirty array
dirty_way  output  w_index  way driven to dirty array
pmem_read  output  1  line fill request, level until pmem_resp
pmem_write  output  1  line writeback request, level until pmem_resp
wb_addr_sel  output  1  1 = pmem address from victim tag, 0 = request tag
line_load  output  1  one-cycle strobe: write refill data, tag, valid into victim way
load_way  output  w_index  way targeted by line_load / CPU write data
lru_update  output  1  one-cycle strobe: mark load_way most-recently-used

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. Registered: state, is_write, victim (w_index).
- Reset (rst high at posedge): state=IDLE, is_write=0, victim=0. All outputs are Moore/Mealy decodes of state and are 0 in IDLE with no request.
- Reset mid-transaction abandons it: pmem_read/pmem_write drop in the cycle after reset is sampled; no mem_resp is issued.
- dirty_set = set_idx at all times.
- IDLE:
  - mem_read|mem_write -> COMPARE.
  - is_write <= mem_write; write wins if both are asserted.
  - dirty_op=00.
- COMPARE, hit=1:
  - mem_resp=1, lru_update=1, load_way=hit_way, dirty_way=hit_way.
  - dirty_op=01 if is_write, else 00.
  - -> IDLE.
- COMPARE, hit=0:
  - victim <= lru_way; dirty_way=lru_way; no mem_resp.
  - dirty_in=1 -> WRITEBACK; dirty_in=0 -> ALLOCATE.
- WRITEBACK:
  - pmem_write=1, wb_addr_sel=1, dirty_way=victim.
  - Hold until pmem_resp. On pmem_resp: dirty_op=10 (unmark victim) that cycle; -> ALLOCATE.
- ALLOCATE:
  - pmem_read=1, wb_addr_sel=0, load_way=victim.
  - Hold until pmem_resp. On pmem_resp: line_load=1 that cycle; -> COMPARE.
  - The re-compare hits and completes the request; a write then marks dirty.
- dirty_op is non-zero for exactly one cycle per mark/unmark event and is 00 in every other cycle.
- pmem_read and pmem_write are never asserted together.
- pmem_resp is ignored in IDLE and COMPARE.
- Latency (cycles from request first visible in IDLE to mem_resp):
  - hit: 1.
  - clean miss: 1 + fill + 1.
  - dirty miss: 1 + writeback + fill + 1.
- Requester deasserts in the cycle after mem_resp. A request visible in IDLE always starts a new transaction; back-to-back hits complete every 2 cycles.
- A repeated miss in COMPARE after ALLOCATE re-enters the miss path; no error state is defined.

Test Plan:
- Read hit: reset, mem_read=1, set_idx=3, hit=1, hit_way=2 -> mem_resp=1 on 2nd edge after request; lru_update=1, load_way=2, dirty_op=00.
- Write hit: mem_write=1, hit=1, hit_way=1 -> same cycle as mem_resp: dirty_op=01, dirty_way=1, dirty_set=set_idx; dirty_op=00 in the next cycle.
- Clean read miss: hit=0, lru_way=3, dirty_in=0 -> pmem_read=1, no pmem_write. pmem_resp after 5 cycles -> line_load=1, load_way=3; then hit=1 in COMPARE -> mem_resp=1.
- Dirty write miss: lru_way=0, dirty_in=1:
  - pmem_write=1, wb_addr_sel=1 until pmem_resp; dirty_op=10 on way 0 in the pmem_resp cycle.
  - Then pmem_read=1; after refill and hit, dirty_op=01 on way 0 with mem_resp=1.
- Reset mid-writeback: assert rst for 1 cycle while pmem_write=1 -> next cycle all outputs 0, state IDLE; a later pmem_resp is ignored (no line_load, no mem_resp).
- mem_read=mem_write=1 with a hit -> treated as write: dirty_op=01; a pmem_resp pulse in IDLE produces no outputs.

Source files
------------

// File: rtl/cache_control.sv
// Per-request control FSM for a set-associative cache: hit/miss sequencing,
// dirty-victim writeback, line refill and dirty-array mark/unmark commands.
module cache_control #(
  parameter int s_index = 4,
  parameter int w_index = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [s_index-1:0] set_idx,
  input  logic               hit,
  input  logic [w_index-1:0] hit_way,
  input  logic [w_index-1:0] lru_way,
  input  logic               dirty_in,
  input  logic               pmem_resp,
  output logic               mem_resp,
  output logic [1:0]         dirty_op,
  output logic [s_index-1:0] dirty_set,
  output logic [w_index-1:0] dirty_way,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               wb_addr_sel,
  output logic               line_load,
  output logic [w_index-1:0] load_way,
  output logic               lru_update
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_IDLE   = 2'b00;
  localparam logic [1:0] OP_MARK   = 2'b01;
  localparam logic [1:0] OP_UNMARK = 2'b10;

  state_t             state, state_nxt;
  logic               is_write, is_write_nxt;
  logic [w_index-1:0] victim, victim_nxt;

  // The dirty array is always addressed by the set of the request in flight.
  assign dirty_set = set_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      is_write <= 1'b0;
      victim   <= '0;
    end else begin
      state    <= state_nxt;
      is_write <= is_write_nxt;
      victim   <= victim_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    is_write_nxt = is_write;
    victim_nxt   = victim;
    mem_resp     = 1'b0;
    dirty_op     = OP_IDLE;
    dirty_way    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    wb_addr_sel  = 1'b0;
    line_load    = 1'b0;
    load_way     = '0;
    lru_update   = 1'b0;

    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_nxt    = COMPARE;
          is_write_nxt = mem_write;
        end
      end

      COMPARE: begin
        if (hit) begin
          mem_resp   = 1'b1;
          lru_update = 1'b1;
          load_way   = hit_way;
          dirty_way  = hit_way;
          dirty_op   = is_write ? OP_MARK : OP_IDLE;
          state_nxt  = IDLE;
        end else begin
          // Victim is latched here; the LRU input may move while memory works.
          victim_nxt = lru_way;
          dirty_way  = lru_way;
          state_nxt  = dirty_in ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        pmem_write  = 1'b1;
        wb_addr_sel = 1'b1;
        dirty_way   = victim;
        if (pmem_resp) begin
          dirty_op  = OP_UNMARK;
          state_nxt = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        load_way  = victim;
        dirty_way = victim;
        if (pmem_resp) begin
          line_load = 1'b1;
          state_nxt = COMPARE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Invariants of the memory handshake and dirty-array command encoding.
  assert property (@(posedge clk) disable iff (rst) !(pmem_read && pmem_write));
  assert property (@(posedge clk) disable iff (rst) dirty_op != 2'b11);

endmodule
